// File: rtl/instr_encoder_if.sv
// Handshake and instruction-memory write bus for instr_encoder.
// master drives operations and control pulses; slave is the encoder itself.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, base_addr, finish, in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
    );

    modport slave (
        input  start, base_addr, finish, in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Symbolic-op to MIPS word encoder with a 4-entry FIFO; streams encoded words
// into consecutive instruction-memory addresses starting at base_addr.
module instr_encoder #(
    parameter int GROUP  = 7,
    parameter int ADDR_W = 8
) (
    input logic             clk,
    input logic             rst,
    instr_encoder_if.slave  bus
);
    localparam logic [5:0]      OP_R      = 6'(GROUP);
    localparam logic [5:0]      OP_LW     = 6'(GROUP + 1);
    localparam logic [5:0]      OP_SW     = 6'(GROUP + 2);
    localparam logic [4:0]      SHAMT     = 5'd10;
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
    } entry_t;

    function automatic logic [31:0] encode_word(input entry_t e);
        logic [31:0] w;
        w = 32'd0;
        case (e.op)
            3'd0:    w = {OP_R, e.rs, e.rt, e.rd, SHAMT, 6'd32};
            3'd1:    w = {OP_R, e.rs, e.rt, e.rd, SHAMT, 6'd34};
            3'd2:    w = {OP_R, e.rs, e.rt, e.rd, SHAMT, 6'd36};
            3'd3:    w = {OP_R, e.rs, e.rt, e.rd, SHAMT, 6'd37};
            3'd4:    w = {OP_R, e.rs, e.rt, e.rd, SHAMT, 6'd50};
            3'd5:    w = {OP_LW, e.rs, e.rt, e.imm};
            3'd6:    w = {OP_SW, e.rs, e.rt, e.imm};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    state_t            state_r, state_n;
    entry_t            fifo_r [4];
    entry_t            head_s;
    logic [1:0]        wr_ptr_r, rd_ptr_r;
    logic [2:0]        occ_r, occ_n;
    logic              push_s, pop_s, done_s, in_ready_n_s;
    logic              in_ready_r, mem_we_r, busy_r, done_r, err_r;
    logic [ADDR_W-1:0] addr_r, mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [ADDR_W:0]   count_r;

    // start flushes, so anything arriving or leaving on that edge is discarded
    assign push_s = bus.in_valid && in_ready_r && !bus.start;
    assign pop_s  = (occ_r != 3'd0) && (state_r != ST_IDLE) && !bus.start;
    assign head_s = fifo_r[rd_ptr_r];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic; done fires on the drain-complete transition
    always_comb begin
        state_n = state_r;
        done_s  = 1'b0;
        if (bus.start) begin
            state_n = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: state_n = ST_IDLE;
                ST_RUN: begin
                    if (bus.finish) state_n = ST_DRAIN;
                    else            state_n = ST_RUN;
                end
                ST_DRAIN: begin
                    if (occ_r == 3'd0) begin
                        state_n = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_n = ST_DRAIN;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Next FIFO occupancy and the registered ready it implies
    always_comb begin
        occ_n = occ_r;
        if (bus.start) begin
            occ_n = 3'd0;
        end else if (push_s && !pop_s) begin
            occ_n = occ_r + 3'd1;
        end else if (pop_s && !push_s) begin
            occ_n = occ_r - 3'd1;
        end else begin
            occ_n = occ_r;
        end
        in_ready_n_s = (state_n == ST_RUN) && (occ_n != 3'd4);
    end

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= '{op: bus.in_op, rs: bus.in_rs, rt: bus.in_rt,
                                  rd: bus.in_rd, imm: bus.in_imm};
        end
    end

    // Pointers, address/count tracking and registered write outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= 2'd0;
            rd_ptr_r    <= 2'd0;
            occ_r       <= 3'd0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
            addr_r      <= '0;
            count_r     <= '0;
        end else begin
            occ_r      <= occ_n;
            in_ready_r <= in_ready_n_s;
            busy_r     <= (state_n != ST_IDLE);
            done_r     <= done_s;
            if (bus.start) begin
                wr_ptr_r <= 2'd0;
                rd_ptr_r <= 2'd0;
                addr_r   <= bus.base_addr;
                count_r  <= '0;
                err_r    <= 1'b0;
                mem_we_r <= 1'b0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + 2'd1;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + 2'd1;
                    if (head_s.op == 3'd7) begin
                        mem_we_r <= 1'b0;
                        err_r    <= 1'b1;
                    end else begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= addr_r;
                        mem_wdata_r <= encode_word(head_s);
                        addr_r      <= addr_r + 1'b1;
                        if (count_r != COUNT_MAX) begin
                            count_r <= count_r + 1'b1;
                        end
                        // writing the top address wraps the next one to zero
                        if (addr_r == {ADDR_W{1'b1}}) begin
                            err_r <= 1'b1;
                        end
                    end
                end else begin
                    mem_we_r <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.count     = count_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed instruction words, write
// addresses, latency, drain/done timing, illegal ops, wrap and mid-run reset.
module tb_instr_encoder;
    logic clk;
    logic rst;
    int   n_asserts = 0;
    int   n_fails   = 0;
    int   cyc       = 0;
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    logic [7:0]  wa_q [$];
    logic [31:0] wd_q [$];
    int          wc_q [$];

    instr_encoder_if #(.ADDR_W(8)) bus ();

    instr_encoder #(.GROUP(7), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // write/done monitor sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
            wc_q.push_back(cyc);
        end
        if (bus.done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_imm   = imm;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] base);
        bus.start     = 1'b1;
        bus.base_addr = base;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic finish_and_wait(input int dbase, input string tag);
        int k;
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        k = 0;
        while (done_cnt == dbase && k < 30) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check({tag, "_done_once"}, 32'(done_cnt - dbase), 32'd1);
        check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_count"}, 32'(bus.count), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    logic [31:0] exp_stream [6] = '{32'h1C22_1AA2, 32'h1C22_1AA4, 32'h1C22_1AA5,
                                    32'h1C22_1AB2, 32'h2085_0008, 32'h2486_FFFC};

    initial begin
        int wbase;
        int dbase;
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = 8'd0; bus.finish = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_rs = 5'd0;
        bus.in_rt = 5'd0; bus.in_rd = 5'd0; bus.in_imm = 16'd0;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // single ADD: 2-cycle latency
        do_start(8'h10);
        check("run_in_ready", 32'(bus.in_ready), 32'd1);
        check("run_busy", 32'(bus.busy), 32'd1);
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        check("add_no_we_yet", 32'(bus.mem_we), 32'd0);
        tick();
        check("add_we", 32'(bus.mem_we), 32'd1);
        check("add_addr", 32'(bus.mem_addr), 32'h10);
        check("add_data", bus.mem_wdata, 32'h1C22_1AA0);
        check("add_count", 32'(bus.count), 32'd1);
        tick();
        check("add_we_one_cycle", 32'(bus.mem_we), 32'd0);
        check("add_data_held", bus.mem_wdata, 32'h1C22_1AA0);

        // back-to-back stream after restart
        do_start(8'h10);
        check("restart_count", 32'(bus.count), 32'd0);
        wbase = wa_q.size();
        dbase = done_cnt;
        send(3'd1, 5'd1, 5'd2, 5'd3, 16'd0);
        send(3'd2, 5'd1, 5'd2, 5'd3, 16'd0);
        send(3'd3, 5'd1, 5'd2, 5'd3, 16'd0);
        send(3'd4, 5'd1, 5'd2, 5'd3, 16'd0);
        send(3'd5, 5'd4, 5'd5, 5'd0, 16'h0008);
        send(3'd6, 5'd4, 5'd6, 5'd0, 16'hFFFC);
        finish_and_wait(dbase, "stream");
        check("stream_nwrites", 32'(wa_q.size() - wbase), 32'd6);
        if (wa_q.size() - wbase == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("stream_addr%0d", i), 32'(wa_q[wbase+i]), 32'(8'h10 + i));
                check($sformatf("stream_data%0d", i), wd_q[wbase+i], exp_stream[i]);
                if (i > 0) begin
                    check($sformatf("stream_gap%0d", i), 32'(wc_q[wbase+i] - wc_q[wbase+i-1]), 32'd1);
                end
            end
            check("stream_done_timing", 32'(done_cyc - wc_q[wbase+5]), 32'd1);
        end
        check("stream_count", 32'(bus.count), 32'd6);

        // in_valid held while start issued; no entry lost
        wbase = wa_q.size();
        dbase = done_cnt;
        bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_rd = 5'd0;
        bus.start = 1'b1; bus.base_addr = 8'h50;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_rd = 5'(i);
            check($sformatf("hold_ready%0d", i), 32'(bus.in_ready), 32'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        finish_and_wait(dbase, "hold");
        check("hold_nwrites", 32'(wa_q.size() - wbase), 32'd8);
        if (wa_q.size() - wbase == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("hold_addr%0d", i), 32'(wa_q[wbase+i]), 32'(8'h50 + i));
                check($sformatf("hold_data%0d", i), wd_q[wbase+i], 32'h1C22_02A0 | 32'(i << 11));
            end
        end

        // illegal op between two ADDs
        do_start(8'h20);
        wbase = wa_q.size();
        dbase = done_cnt;
        send(3'd0, 5'd1, 5'd2, 5'd1, 16'd0);
        send(3'd7, 5'd1, 5'd2, 5'd9, 16'd0);
        send(3'd0, 5'd1, 5'd2, 5'd2, 16'd0);
        finish_and_wait(dbase, "illegal");
        check("illegal_nwrites", 32'(wa_q.size() - wbase), 32'd2);
        if (wa_q.size() - wbase == 2) begin
            check("illegal_addr0", 32'(wa_q[wbase]), 32'h20);
            check("illegal_addr1", 32'(wa_q[wbase+1]), 32'h21);
            check("illegal_data0", wd_q[wbase], 32'h1C22_0AA0);
            check("illegal_data1", wd_q[wbase+1], 32'h1C22_12A0);
        end
        check("illegal_err", 32'(bus.err), 32'd1);
        check("illegal_count", 32'(bus.count), 32'd2);
        repeat (3) tick();
        check("illegal_err_sticky", 32'(bus.err), 32'd1);

        // address wrap from 0xFF
        do_start(8'hFF);
        check("wrap_err_cleared", 32'(bus.err), 32'd0);
        wbase = wa_q.size();
        dbase = done_cnt;
        send(3'd0, 5'd1, 5'd2, 5'd5, 16'd0);
        send(3'd0, 5'd1, 5'd2, 5'd6, 16'd0);
        finish_and_wait(dbase, "wrap");
        check("wrap_nwrites", 32'(wa_q.size() - wbase), 32'd2);
        if (wa_q.size() - wbase == 2) begin
            check("wrap_addr0", 32'(wa_q[wbase]), 32'hFF);
            check("wrap_addr1", 32'(wa_q[wbase+1]), 32'h00);
        end
        check("wrap_err", 32'(bus.err), 32'd1);
        check("wrap_count", 32'(bus.count), 32'd2);

        // reset mid-stream
        do_start(8'h60);
        send(3'd0, 5'd1, 5'd2, 5'd1, 16'd0);
        send(3'd0, 5'd1, 5'd2, 5'd2, 16'd0);
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        wbase = wa_q.size();
        repeat (3) tick();
        check("midrst_no_writes", 32'(wa_q.size() - wbase), 32'd0);
        rst = 1'b0;
        tick();
        do_start(8'h40);
        wbase = wa_q.size();
        dbase = done_cnt;
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        finish_and_wait(dbase, "fresh");
        check("fresh_nwrites", 32'(wa_q.size() - wbase), 32'd1);
        if (wa_q.size() - wbase == 1) begin
            check("fresh_addr", 32'(wa_q[wbase]), 32'h40);
            check("fresh_data", wd_q[wbase], 32'h1C22_1AA0);
        end
        check("fresh_count", 32'(bus.count), 32'd1);
        check("fresh_err", 32'(bus.err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
